ibex_pmp_csr: RTL and testbench

IBEX_PMP_CSR -- requirements
Module: ibex_pmp_csr

---
 rtl/ibex_pkg.sv | 42 ++++
 rtl/ibex_pmp_cfg_legalize.sv | 32 +++
 rtl/ibex_pmp_csr.sv | 211 +++++++++++++++++++++
 tb/tb_ibex_pmp_csr.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared PMP types: entry configuration, machine security configuration,
// CSR selector and the CSR block's sequencing states.
package ibex_pkg;

    typedef enum logic [1:0] {
        PMP_MODE_OFF   = 2'b00,
        PMP_MODE_TOR   = 2'b01,
        PMP_MODE_NA4   = 2'b10,
        PMP_MODE_NAPOT = 2'b11
    } pmp_cfg_mode_e;

    typedef struct packed {
        logic          lock;
        pmp_cfg_mode_e mode;
        logic          exec;
        logic          write;
        logic          read;
    } pmp_cfg_t;

    typedef struct packed {
        logic rlb;
        logic mmwp;
        logic mml;
    } pmp_mseccfg_t;

    typedef enum logic [1:0] {
        PMP_CSR_CFG     = 2'd0,
        PMP_CSR_ADDR    = 2'd1,
        PMP_CSR_MSECCFG = 2'd2
    } pmp_csr_sel_e;

    typedef enum logic {
        PMP_CSR_IDLE  = 1'b0,
        PMP_CSR_CLEAR = 1'b1
    } pmp_csr_state_e;

    // Architectural pmpcfg byte layout: L, two reserved zeros, A, X, W, R.
    function automatic logic [7:0] pmp_cfg_to_byte(input pmp_cfg_t c);
        return {c.lock, 2'b00, c.mode, c.exec, c.write, c.read};
    endfunction

endpackage

// File: rtl/ibex_pmp_cfg_legalize.sv
// Turns one written pmpcfg byte into the value that may be stored, and flags
// bytes that must be dropped entirely under machine-mode lockdown.
module ibex_pmp_cfg_legalize
    import ibex_pkg::*;
#(
    parameter int unsigned PMPGranularity = 0
) (
    input  logic [7:0]   wdata,
    input  pmp_mseccfg_t mseccfg,
    output pmp_cfg_t     cfg,
    output logic         reject
);

    // Legalise permission and mode fields; R=0,W=1 is only meaningful under MML.
    always_comb begin
        cfg.lock = wdata[7];
        cfg.exec = wdata[2];
        cfg.read = wdata[0];
        if (!mseccfg.mml && !wdata[0] && wdata[1]) begin
            cfg.write = 1'b0;
        end else begin
            cfg.write = wdata[1];
        end
        if ((PMPGranularity != 32'd0) && (wdata[4:3] == 2'b10)) begin
            cfg.mode = PMP_MODE_OFF;
        end else begin
            cfg.mode = pmp_cfg_mode_e'(wdata[4:3]);
        end
        reject = mseccfg.mml & ~mseccfg.rlb & wdata[7] & wdata[2] & ~(~wdata[0] & wdata[1]);
    end

endmodule

// File: rtl/ibex_pmp_csr.sv
// PMP CSR file: pmpcfg/pmpaddr/mseccfg storage with lock rules, a one-cycle
// response path, and a sweep that clears every unlocked entry.
module ibex_pmp_csr
    import ibex_pkg::*;
#(
    parameter int unsigned PMPGranularity = 0,
    parameter int unsigned PMPNumRegions  = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         csr_req_i,
    input  logic         csr_we_i,
    input  logic [1:0]   csr_sel_i,
    input  logic [3:0]   csr_idx_i,
    input  logic [31:0]  csr_wdata_i,
    output logic         csr_gnt_o,
    output logic         csr_rvalid_o,
    output logic [31:0]  csr_rdata_o,
    output logic         csr_err_o,
    input  logic         clear_req_i,
    output logic         clear_busy_o,
    output pmp_cfg_t     csr_pmp_cfg_o [PMPNumRegions],
    output logic [33:0]  csr_pmp_addr_o [PMPNumRegions],
    output pmp_mseccfg_t csr_pmp_mseccfg_o
);

    localparam logic [3:0] CFG_MAX_IDX = 4'((PMPNumRegions - 1) / 4);
    localparam logic [4:0] NUM_REGIONS = 5'(PMPNumRegions);
    localparam logic [3:0] LAST_IDX    = 4'(PMPNumRegions - 1);
    localparam int         G           = int'(PMPGranularity);

    pmp_csr_state_e           state_q, state_d;
    logic [3:0]               clr_idx_q, clr_idx_d;
    pmp_cfg_t                 cfg_q [PMPNumRegions];
    logic [33:0]              addr_q [PMPNumRegions];
    pmp_mseccfg_t             mseccfg_q;
    pmp_cfg_t                 legal_cfg [PMPNumRegions];
    logic [PMPNumRegions-1:0] legal_reject, locked, lock_bits, tor_locked;
    logic [PMPNumRegions-1:0] cfg_wr, addr_wr, clr_hit;
    logic                     idx_err, wr_ok, cfg_sel, addr_sel, msec_sel;
    logic [31:0]              rdata_s;

    // Low address bits read back according to the region granularity.
    function automatic logic [31:0] addr_read(input logic [33:0] a, input pmp_cfg_mode_e m);
        logic [31:0] r;
        r = a[33:2];
        for (int b = 0; b < 32; b++) begin
            if ((b <= G - 2) && (m == PMP_MODE_NAPOT)) begin
                r[b] = 1'b1;
            end
            if ((b <= G - 1) && ((m == PMP_MODE_OFF) || (m == PMP_MODE_TOR))) begin
                r[b] = 1'b0;
            end
        end
        return r;
    endfunction

    assign csr_gnt_o    = csr_req_i & (state_q == PMP_CSR_IDLE) & ~clear_req_i & ~rst_i;
    assign clear_busy_o = (state_q == PMP_CSR_CLEAR);
    assign cfg_sel      = (csr_sel_i == PMP_CSR_CFG);
    assign addr_sel     = (csr_sel_i == PMP_CSR_ADDR);
    assign msec_sel     = (csr_sel_i == PMP_CSR_MSECCFG);
    assign wr_ok        = csr_gnt_o & csr_we_i & ~idx_err;
    assign csr_pmp_mseccfg_o = mseccfg_q;

    // Index range check for the selected CSR class.
    always_comb begin
        case (csr_sel_i)
            PMP_CSR_CFG:     idx_err = (csr_idx_i > CFG_MAX_IDX);
            PMP_CSR_ADDR:    idx_err = ({1'b0, csr_idx_i} >= NUM_REGIONS);
            PMP_CSR_MSECCFG: idx_err = 1'b0;
            default:         idx_err = 1'b1;
        endcase
    end

    // Read mux over the pre-write state.
    always_comb begin
        rdata_s = 32'h0;
        if (idx_err) begin
            rdata_s = 32'h0;
        end else begin
            case (csr_sel_i)
                PMP_CSR_CFG: begin
                    for (int i = 0; i < int'(PMPNumRegions); i++) begin
                        if (csr_idx_i == 4'(i / 4)) begin
                            rdata_s[8*(i%4) +: 8] = pmp_cfg_to_byte(cfg_q[i]);
                        end else begin
                            rdata_s = rdata_s;
                        end
                    end
                end
                PMP_CSR_ADDR: begin
                    for (int i = 0; i < int'(PMPNumRegions); i++) begin
                        if (csr_idx_i == 4'(i)) begin
                            rdata_s = addr_read(addr_q[i], cfg_q[i].mode);
                        end else begin
                            rdata_s = rdata_s;
                        end
                    end
                end
                PMP_CSR_MSECCFG: rdata_s = {29'h0, mseccfg_q};
                default:         rdata_s = 32'h0;
            endcase
        end
    end

    // Sweep sequencing: a clear request parks the block for one cycle per entry.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            PMP_CSR_IDLE: begin
                if (clear_req_i) begin
                    state_d   = PMP_CSR_CLEAR;
                    clr_idx_d = 4'd0;
                end else begin
                    state_d = PMP_CSR_IDLE;
                end
            end
            PMP_CSR_CLEAR: begin
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = PMP_CSR_IDLE;
                    clr_idx_d = 4'd0;
                end else begin
                    clr_idx_d = clr_idx_q + 4'd1;
                end
            end
            default: begin
                state_d   = PMP_CSR_IDLE;
                clr_idx_d = 4'd0;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= PMP_CSR_IDLE;
            clr_idx_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Response registers: one pulse per grant, zero data on error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            csr_rvalid_o <= 1'b0;
            csr_err_o    <= 1'b0;
            csr_rdata_o  <= 32'h0;
        end else begin
            csr_rvalid_o <= csr_gnt_o;
            csr_err_o    <= csr_gnt_o & idx_err;
            csr_rdata_o  <= csr_gnt_o ? rdata_s : 32'h0;
        end
    end

    // mml/mmwp only ever set; rlb may not be raised while a lock is live.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mseccfg_q <= '0;
        end else if (wr_ok && msec_sel) begin
            mseccfg_q.mml  <= mseccfg_q.mml | csr_wdata_i[0];
            mseccfg_q.mmwp <= mseccfg_q.mmwp | csr_wdata_i[1];
            mseccfg_q.rlb  <= csr_wdata_i[2] & (mseccfg_q.rlb | ~(|lock_bits));
        end else begin
            mseccfg_q <= mseccfg_q;
        end
    end

    for (genvar i = 0; i < PMPNumRegions; i++) begin : g_entry
        ibex_pmp_cfg_legalize #(
            .PMPGranularity(PMPGranularity)
        ) u_legalize (
            .wdata  (csr_wdata_i[8*(i%4) +: 8]),
            .mseccfg(mseccfg_q),
            .cfg    (legal_cfg[i]),
            .reject (legal_reject[i])
        );

        assign lock_bits[i] = cfg_q[i].lock;
        assign locked[i]    = cfg_q[i].lock & ~mseccfg_q.rlb;
        if (i + 1 < PMPNumRegions) begin : g_tor
            assign tor_locked[i] = locked[i+1] & (cfg_q[i+1].mode == PMP_MODE_TOR);
        end else begin : g_last
            assign tor_locked[i] = 1'b0;
        end
        assign cfg_wr[i]  = wr_ok & cfg_sel & (csr_idx_i == 4'(i / 4)) & ~locked[i] & ~legal_reject[i];
        assign addr_wr[i] = wr_ok & addr_sel & (csr_idx_i == 4'(i)) & ~locked[i] & ~tor_locked[i];
        assign clr_hit[i] = (state_q == PMP_CSR_CLEAR) & (clr_idx_q == 4'(i)) & ~locked[i];
        assign csr_pmp_cfg_o[i]  = cfg_q[i];
        assign csr_pmp_addr_o[i] = addr_q[i];

        // Entry storage; sweep and CSR writes never coincide since grants need IDLE.
        always_ff @(posedge clk_i) begin
            if (rst_i || clr_hit[i]) begin
                cfg_q[i]  <= '0;
                addr_q[i] <= 34'h0;
            end else begin
                if (cfg_wr[i]) begin
                    cfg_q[i] <= legal_cfg[i];
                end
                if (addr_wr[i]) begin
                    addr_q[i] <= {csr_wdata_i, 2'b00};
                end
            end
        end
    end

endmodule

// File: tb/tb_ibex_pmp_csr.sv
// Randomised bench for ibex_pmp_csr against a rule-level model of the CSR
// file, preceded by directed scenarios with hand-computed expectations.
module tb_ibex_pmp_csr;
    import ibex_pkg::*;

    localparam int N = 4;
    localparam int G = 2;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         csr_req_i = 1'b0, csr_we_i = 1'b0, clear_req_i = 1'b0;
    logic [1:0]   csr_sel_i = 2'd0;
    logic [3:0]   csr_idx_i = 4'd0;
    logic [31:0]  csr_wdata_i = 32'h0;
    logic         csr_gnt_o, csr_rvalid_o, csr_err_o, clear_busy_o;
    logic [31:0]  csr_rdata_o;
    pmp_cfg_t     cfg_o [N];
    logic [33:0]  addr_o [N];
    pmp_mseccfg_t msec_o;

    ibex_pmp_csr #(.PMPGranularity(G), .PMPNumRegions(N)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .csr_req_i(csr_req_i), .csr_we_i(csr_we_i),
        .csr_sel_i(csr_sel_i), .csr_idx_i(csr_idx_i), .csr_wdata_i(csr_wdata_i),
        .csr_gnt_o(csr_gnt_o), .csr_rvalid_o(csr_rvalid_o), .csr_rdata_o(csr_rdata_o),
        .csr_err_o(csr_err_o), .clear_req_i(clear_req_i), .clear_busy_o(clear_busy_o),
        .csr_pmp_cfg_o(cfg_o), .csr_pmp_addr_o(addr_o), .csr_pmp_mseccfg_o(msec_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference state: cfg kept as architectural bytes, addr as the written word.
    logic [7:0]  m_cfg [N];
    logic [31:0] m_addr [N];
    logic        m_mml = 1'b0, m_mmwp = 1'b0, m_rlb = 1'b0, m_busy = 1'b0;
    int          m_pos = 0;
    logic        e_rvalid = 1'b0, e_err = 1'b0;
    logic [31:0] e_rdata = 32'h0;
    logic        last_gnt;
    int          n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else n_pass++;
    endtask

    function automatic bit m_locked(input int e);
        return m_cfg[e][7] && !m_rlb;
    endfunction

    function automatic bit m_idx_err(input logic [1:0] sel, input logic [3:0] idx);
        if (sel == 2'd0) return int'(idx) > (N - 1) / 4;
        if (sel == 2'd1) return int'(idx) >= N;
        if (sel == 2'd2) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] sel, input logic [3:0] idx);
        logic [31:0] v;
        v = 32'h0;
        if (sel == 2'd0) begin
            for (int j = 0; j < 4; j++)
                if (int'(idx) * 4 + j < N) v[8*j +: 8] = m_cfg[int'(idx) * 4 + j];
        end else if (sel == 2'd1) begin
            v = m_addr[idx];
            for (int b = 0; b < 32; b++) begin
                if (b < G - 1 && m_cfg[idx][4:3] == 2'b11) v[b] = 1'b1;
                if (b < G && m_cfg[idx][4:3] < 2'b10) v[b] = 1'b0;
            end
        end else begin
            v = {29'h0, m_rlb, m_mmwp, m_mml};
        end
        return v;
    endfunction

    task automatic m_legal(input logic [7:0] b, output logic [7:0] o, output bit rej);
        o = b & 8'h9F;
        if (!m_mml && o[1:0] == 2'b10) o[1:0] = 2'b00;
        if (G > 0 && o[4:3] == 2'b10) o[4:3] = 2'b00;
        rej = m_mml && !m_rlb && b[7] && b[2] && !(b[1:0] == 2'b10);
    endtask

    function automatic bit m_gnt();
        return csr_req_i && !m_busy && !clear_req_i && !rst_i;
    endfunction

    task automatic model_edge();
        bit g, ie, rej, anylock;
        bit lk [N];
        logic [7:0] o;
        int e;
        g = m_gnt();
        if (rst_i) begin
            for (int i = 0; i < N; i++) begin m_cfg[i] = 8'h0; m_addr[i] = 32'h0; end
            {m_mml, m_mmwp, m_rlb, m_busy} = 4'b0;
            m_pos = 0; e_rvalid = 1'b0; e_err = 1'b0; e_rdata = 32'h0;
        end else begin
            ie = m_idx_err(csr_sel_i, csr_idx_i);
            e_rvalid = g;
            e_err    = g && ie;
            e_rdata  = (g && !ie) ? m_read(csr_sel_i, csr_idx_i) : 32'h0;
            for (int i = 0; i < N; i++) lk[i] = m_locked(i);
            anylock = 1'b0;
            for (int i = 0; i < N; i++) anylock |= m_cfg[i][7];
            if (m_busy) begin
                if (!lk[m_pos]) begin m_cfg[m_pos] = 8'h0; m_addr[m_pos] = 32'h0; end
                m_pos++;
                if (m_pos == N) m_busy = 1'b0;
            end else if (clear_req_i) begin
                m_busy = 1'b1; m_pos = 0;
            end else if (g && csr_we_i && !ie) begin
                if (csr_sel_i == 2'd0) begin
                    for (int j = 0; j < 4; j++) begin
                        e = int'(csr_idx_i) * 4 + j;
                        if (e < N && !lk[e]) begin
                            m_legal(csr_wdata_i[8*j +: 8], o, rej);
                            if (!rej) m_cfg[e] = o;
                        end
                    end
                end else if (csr_sel_i == 2'd1) begin
                    e = int'(csr_idx_i);
                    if (!lk[e] && !(e + 1 < N && lk[e+1] && m_cfg[e+1][4:3] == 2'b01))
                        m_addr[e] = csr_wdata_i;
                end else begin
                    m_mml  = m_mml | csr_wdata_i[0];
                    m_mmwp = m_mmwp | csr_wdata_i[1];
                    m_rlb  = csr_wdata_i[2] && (m_rlb || !anylock);
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("rvalid", 64'(csr_rvalid_o), 64'(e_rvalid));
        chk("err", 64'(csr_err_o), 64'(e_err));
        chk("rdata", 64'(csr_rdata_o), 64'(e_rdata));
        chk("busy", 64'(clear_busy_o), 64'(m_busy));
        chk("mseccfg", 64'(msec_o), 64'({m_rlb, m_mmwp, m_mml}));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("cfg%0d", i), 64'(pmp_cfg_to_byte(cfg_o[i])), 64'(m_cfg[i]));
            chk($sformatf("addr%0d", i), 64'(addr_o[i]), 64'({m_addr[i], 2'b00}));
        end
    endtask

    task automatic cyc(input logic rst, input logic req, input logic we, input logic [1:0] sel,
                       input logic [3:0] idx, input logic [31:0] wd, input logic clr);
        rst_i = rst; csr_req_i = req; csr_we_i = we; csr_sel_i = sel;
        csr_idx_i = idx; csr_wdata_i = wd; clear_req_i = clr;
        @(negedge clk_i);
        last_gnt = csr_gnt_o;
        chk("gnt", 64'(csr_gnt_o), 64'(m_gnt()));
        @(posedge clk_i);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 32'h0, 1'b0);
    endtask

    task automatic reset_dut();
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 32'h0, 1'b0);
    endtask

    initial begin
        int busy_cnt;
        logic [31:0] wd;
        logic [1:0]  sel;
        logic [3:0]  idx;
        for (int i = 0; i < N; i++) begin m_cfg[i] = 8'h0; m_addr[i] = 32'h0; end
        @(posedge clk_i);
        #1;
        reset_dut();
        chk("reset_rvalid", 64'(csr_rvalid_o), 64'h0);
        chk("reset_cfg0", 64'(pmp_cfg_to_byte(cfg_o[0])), 64'h0);

        // Entry 0 NAPOT RWX, entry 1 TOR RWX.
        cyc(1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 32'h0000_0F1F, 1'b0);
        chk("r031_mode", 64'(cfg_o[0].mode), 64'h3);
        chk("r031_rvalid", 64'(csr_rvalid_o), 64'h1);
        chk("r031_err", 64'(csr_err_o), 64'h0);

        // R=0,W=1 without MML collapses to no access; mml is sticky.
        cyc(1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 32'h0000_0F1A, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 32'h0, 1'b0);
        chk("r034_rw", 64'(csr_rdata_o[7:0]), 64'h18);
        cyc(1'b0, 1'b1, 1'b1, 2'd2, 4'd0, 32'h1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 2'd2, 4'd0, 32'h0, 1'b0);
        chk("r034_mml", 64'(msec_o.mml), 64'h1);

        // Locked TOR entry 1 protects addr0 unless rlb was set beforehand.
        reset_dut();
        cyc(1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 32'h0000_8800, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 2'd1, 4'd0, 32'h0000_1000, 1'b0);
        chk("r032_locked", 64'(addr_o[0]), 64'h0);
        reset_dut();
        cyc(1'b0, 1'b1, 1'b1, 2'd2, 4'd0, 32'h4, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 32'h0000_8800, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 2'd1, 4'd0, 32'h0000_1000, 1'b0);
        chk("r032_rlb", 64'(addr_o[0]), 64'h4000);

        // Sweep with entries 0 and 2 locked.
        reset_dut();
        for (int i = 0; i < N; i++) cyc(1'b0, 1'b1, 1'b1, 2'd1, 4'(i), 32'h111 * (i + 1), 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 32'h0F99_0F99, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 32'h0, 1'b1);
        chk("r033_gnt", 64'(last_gnt), 64'h0);
        busy_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            if (clear_busy_o) busy_cnt++;
            idle();
        end
        chk("r033_busy_cycles", 64'(busy_cnt), 64'd4);
        chk("r033_cfg1", 64'(pmp_cfg_to_byte(cfg_o[1])), 64'h0);
        chk("r033_addr3", 64'(addr_o[3]), 64'h0);
        chk("r033_cfg0", 64'(pmp_cfg_to_byte(cfg_o[0])), 64'h99);
        chk("r033_addr2", 64'(addr_o[2]), 64'hCCC);

        // Out-of-range index, then reset in the middle of a sweep.
        cyc(1'b0, 1'b1, 1'b0, 2'd1, 4'd9, 32'h0, 1'b0);
        chk("r035_rvalid", 64'(csr_rvalid_o), 64'h1);
        chk("r035_err", 64'(csr_err_o), 64'h1);
        chk("r035_rdata", 64'(csr_rdata_o), 64'h0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 32'h0, 1'b1);
        idle();
        idle();
        reset_dut();
        chk("r035_busy", 64'(clear_busy_o), 64'h0);
        chk("r035_cfg0", 64'(pmp_cfg_to_byte(cfg_o[0])), 64'h0);
        chk("r035_addr2", 64'(addr_o[2]), 64'h0);

        for (int n = 0; n < 2500; n++) begin
            wd = $urandom;
            for (int j = 0; j < 4; j++) if ($urandom_range(0, 9) != 0) wd[8*j+7] = 1'b0;
            sel = 2'($urandom_range(0, 2));
            if (sel == 2'd2) begin
                wd[0] = ($urandom_range(0, 19) == 0);
                wd[1] = ($urandom_range(0, 9) == 0);
            end
            if (sel == 2'd1) idx = 4'($urandom_range(0, 5));
            else if (sel == 2'd0) idx = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            else idx = 4'($urandom);
            cyc(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) < 7),
                1'($urandom_range(0, 1)), sel, idx, wd, 1'($urandom_range(0, 29) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
